// File: rtl/multicycle_control_if.sv
// Control-unit bundle between the multi-cycle controller (master) and the RV32 datapath/memory (slave).
interface multicycle_control_if #(
   parameter int ALUOP_W = 2,
   parameter int CNT_W   = 32
);
   logic [6:0]         opcode;
   logic               mem_ready;
   logic               pc_write;
   logic               ir_write;
   logic               i_or_d;
   logic               branch;
   logic               mem_read;
   logic               mem_to_reg;
   logic               mem_write;
   logic               alu_src;
   logic               reg_write;
   logic [ALUOP_W-1:0] alu_op;
   logic               illegal;
   logic               mem_timeout;
   logic [CNT_W-1:0]   retired;
   logic [2:0]         state_o;

   modport master (
      input  opcode, mem_ready,
      output pc_write, ir_write, i_or_d, branch, mem_read, mem_to_reg, mem_write,
             alu_src, reg_write, alu_op, illegal, mem_timeout, retired, state_o
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, ir_write, i_or_d, branch, mem_read, mem_to_reg, mem_write,
             alu_src, reg_write, alu_op, illegal, mem_timeout, retired, state_o
   );
endinterface

// File: rtl/multicycle_control.sv
// RV32 multi-cycle control FSM: 3-5 cycles per instruction plus one per mem_ready-low cycle in FETCH/MEM.
// Optional ILLEGAL_TRAP_EN routes unknown opcodes through a one-cycle TRAP state.
module multicycle_control #(
   parameter int ALUOP_W  = 2,
   parameter int CNT_W    = 32,
   parameter int MAX_WAIT = 15
) (
   input logic                 clk,
   input logic                 rst,
   multicycle_control_if.master bus
);
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      TRAP   = 3'd6
   } state_t;

   state_t            state_q, state_d;
   logic [6:0]        op_q, op_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic              mem_timeout_q, mem_timeout_d;

   logic       pc_write_c, ir_write_c, i_or_d_c, branch_c, mem_read_c, mem_to_reg_c;
   logic       mem_write_c, alu_src_c, reg_write_c, illegal_c, retire_c, in_wait_c;
   logic [1:0] alu_op_c;
   logic       is_r, is_load, is_store, is_branch;

   assign is_r      = (op_q == OP_R);
   assign is_load   = (op_q == OP_LOAD);
   assign is_store  = (op_q == OP_STORE);
   assign is_branch = (op_q == OP_BRANCH);

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      pc_write_c   = 1'b0;
      ir_write_c   = 1'b0;
      i_or_d_c     = 1'b0;
      branch_c     = 1'b0;
      mem_read_c   = 1'b0;
      mem_to_reg_c = 1'b0;
      mem_write_c  = 1'b0;
      alu_src_c    = 1'b0;
      reg_write_c  = 1'b0;
      illegal_c    = 1'b0;
      alu_op_c     = 2'b00;
      retire_c     = 1'b0;

      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            mem_read_c = 1'b1;
            pc_write_c = bus.mem_ready;
            ir_write_c = bus.mem_ready;
            if (bus.mem_ready) state_d = DECODE;
         end
         DECODE: begin
            op_d = bus.opcode;
            if (bus.opcode inside {OP_R, OP_LOAD, OP_STORE, OP_BRANCH}) begin
               state_d = EXEC;
            end else begin
`ifdef ILLEGAL_TRAP_EN
               state_d = TRAP;
`else
               state_d = FETCH;
`endif
            end
         end
         EXEC: begin
            if (is_r) begin
               alu_op_c = 2'b10;
               state_d  = WB;
            end else if (is_load || is_store) begin
               alu_src_c = 1'b1;
               state_d   = MEM;
            end else if (is_branch) begin
               alu_op_c = 2'b01;
               branch_c = 1'b1;
               state_d  = FETCH;
               retire_c = 1'b1;
            end else begin
               state_d = FETCH;
            end
         end
         MEM: begin
            i_or_d_c    = 1'b1;
            alu_src_c   = 1'b1;
            mem_read_c  = is_load;
            mem_write_c = is_store;
            if (bus.mem_ready) begin
               if (is_load) begin
                  state_d = WB;
               end else begin
                  state_d  = FETCH;
                  retire_c = 1'b1;
               end
            end
         end
         WB: begin
            reg_write_c  = 1'b1;
            mem_to_reg_c = is_load;
            state_d      = FETCH;
            retire_c     = 1'b1;
         end
         TRAP: begin
`ifdef ILLEGAL_TRAP_EN
            illegal_c = 1'b1;
`endif
            state_d = FETCH;
         end
         default: state_d = IDLE;
      endcase

      // Counter only runs while stalled on memory; any advance clears it.
      in_wait_c = ((state_q == FETCH) || (state_q == MEM)) && !bus.mem_ready;
      if (!in_wait_c)              wait_d = '0;
      else if (wait_q == WAIT_MAX) wait_d = wait_q;
      else                         wait_d = wait_q + WAIT_W'(1);

      mem_timeout_d = mem_timeout_q | (in_wait_c && (wait_d == WAIT_MAX));
      retired_d     = retire_c ? retired_q + CNT_W'(1) : retired_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         op_q          <= '0;
         wait_q        <= '0;
         retired_q     <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         wait_q        <= wait_d;
         retired_q     <= retired_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign bus.pc_write    = pc_write_c;
   assign bus.ir_write    = ir_write_c;
   assign bus.i_or_d      = i_or_d_c;
   assign bus.branch      = branch_c;
   assign bus.mem_read    = mem_read_c;
   assign bus.mem_to_reg  = mem_to_reg_c;
   assign bus.mem_write   = mem_write_c;
   assign bus.alu_src     = alu_src_c;
   assign bus.reg_write   = reg_write_c;
   assign bus.alu_op      = ALUOP_W'(alu_op_c);
   assign bus.illegal     = illegal_c;
   assign bus.mem_timeout = mem_timeout_q;
   assign bus.retired     = retired_q;
   assign bus.state_o     = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction sequencing, memory stalls, timeout, illegal opcode, async reset.
module tb_multicycle_control;
   localparam int ALUOP_W  = 2;
   localparam int CNT_W    = 32;
   localparam int MAX_WAIT = 15;

   // Packed strobe vector order: pc_write ir_write i_or_d branch mem_read mem_to_reg mem_write alu_src reg_write alu_op[1:0] illegal
   localparam logic [11:0] S_PCW  = 12'h800;
   localparam logic [11:0] S_IRW  = 12'h400;
   localparam logic [11:0] S_IORD = 12'h200;
   localparam logic [11:0] S_BR   = 12'h100;
   localparam logic [11:0] S_MRD  = 12'h080;
   localparam logic [11:0] S_M2R  = 12'h040;
   localparam logic [11:0] S_MWR  = 12'h020;
   localparam logic [11:0] S_ASRC = 12'h010;
   localparam logic [11:0] S_RW   = 12'h008;
   localparam logic [11:0] S_SUB  = 12'h002;
   localparam logic [11:0] S_FUNC = 12'h004;
   localparam logic [11:0] S_ILL  = 12'h001;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   multicycle_control_if #(.ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

   multicycle_control #(.ALUOP_W(ALUOP_W), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [11:0] strb;
   assign strb = {bus.pc_write, bus.ir_write, bus.i_or_d, bus.branch, bus.mem_read,
                  bus.mem_to_reg, bus.mem_write, bus.alu_src, bus.reg_write,
                  bus.alu_op[1:0], bus.illegal};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      rst           = 1'b1;
      bus.mem_ready = 1'b1;
      bus.opcode    = 7'b0000000;
      #1;
      chk("rst_state", 32'(bus.state_o), 32'd0);
      chk("rst_strb", 32'(strb), 32'h0);
      chk("rst_retired", bus.retired, 32'd0);
      chk("rst_timeout", 32'(bus.mem_timeout), 32'd0);

      // R-type, zero-wait
      step();
      rst        = 1'b0;
      bus.opcode = 7'b0110011;
      chk("r_idle", 32'(bus.state_o), 32'd0);
      step();
      chk("r_fetch", 32'(bus.state_o), 32'd1);
      chk("r_fetch_strb", 32'(strb), 32'(S_PCW | S_IRW | S_MRD));
      step();
      chk("r_decode", 32'(bus.state_o), 32'd2);
      chk("r_decode_strb", 32'(strb), 32'h0);
      step();
      chk("r_exec", 32'(bus.state_o), 32'd3);
      chk("r_exec_strb", 32'(strb), 32'(S_FUNC));
      step();
      chk("r_wb", 32'(bus.state_o), 32'd5);
      chk("r_wb_strb", 32'(strb), 32'(S_RW));
      chk("r_wb_retired", bus.retired, 32'd0);
      step();
      chk("r_done", 32'(bus.state_o), 32'd1);
      chk("r_retired", bus.retired, 32'd1);

      // Load with two wait cycles in MEM; mem_ready low during EXEC is ignored
      bus.opcode = 7'b0000011;
      step();
      chk("ld_decode", 32'(bus.state_o), 32'd2);
      step();
      chk("ld_exec_strb", 32'(strb), 32'(S_ASRC));
      bus.mem_ready = 1'b0;
      step();
      chk("ld_mem1", 32'(bus.state_o), 32'd4);
      chk("ld_mem1_strb", 32'(strb), 32'(S_IORD | S_ASRC | S_MRD));
      step();
      chk("ld_mem2", 32'(bus.state_o), 32'd4);
      step();
      chk("ld_mem3", 32'(bus.state_o), 32'd4);
      chk("ld_mem3_strb", 32'(strb), 32'(S_IORD | S_ASRC | S_MRD));
      bus.mem_ready = 1'b1;
      step();
      chk("ld_wb", 32'(bus.state_o), 32'd5);
      chk("ld_wb_strb", 32'(strb), 32'(S_RW | S_M2R));
      chk("ld_wb_retired", bus.retired, 32'd1);
      step();
      chk("ld_done", 32'(bus.state_o), 32'd1);
      chk("ld_retired", bus.retired, 32'd2);

      // Store then branch, zero-wait
      bus.opcode = 7'b0100011;
      step();
      chk("st_decode", 32'(bus.state_o), 32'd2);
      step();
      chk("st_exec_strb", 32'(strb), 32'(S_ASRC));
      step();
      chk("st_mem", 32'(bus.state_o), 32'd4);
      chk("st_mem_strb", 32'(strb), 32'(S_IORD | S_ASRC | S_MWR));
      bus.opcode = 7'b1100011;
      step();
      chk("st_done", 32'(bus.state_o), 32'd1);
      chk("st_retired", bus.retired, 32'd3);
      chk("st_fetch_strb", 32'(strb), 32'(S_PCW | S_IRW | S_MRD));
      step();
      chk("br_decode", 32'(bus.state_o), 32'd2);
      step();
      chk("br_exec", 32'(bus.state_o), 32'd3);
      chk("br_exec_strb", 32'(strb), 32'(S_BR | S_SUB));
      step();
      chk("br_done", 32'(bus.state_o), 32'd1);
      chk("br_retired", bus.retired, 32'd4);

      // FETCH stall: timeout after exactly MAX_WAIT wait cycles, sticky afterwards
      bus.mem_ready = 1'b0;
      for (int i = 0; i < MAX_WAIT - 1; i++) step();
      chk("to_before", 32'(bus.mem_timeout), 32'd0);
      chk("to_fetch_strb", 32'(strb), 32'(S_MRD));
      step();
      chk("to_at_max", 32'(bus.mem_timeout), 32'd1);
      chk("to_still_fetch", 32'(bus.state_o), 32'd1);
      step();
      step();
      step();
      chk("to_hold", 32'(bus.mem_timeout), 32'd1);
      bus.mem_ready = 1'b1;
      bus.opcode    = 7'b1111111;
      step();
      chk("ill_decode", 32'(bus.state_o), 32'd2);
      chk("ill_decode_strb", 32'(strb), 32'h0);
      chk("to_sticky", 32'(bus.mem_timeout), 32'd1);
`ifdef ILLEGAL_TRAP_EN
      step();
      chk("ill_trap", 32'(bus.state_o), 32'd6);
      chk("ill_trap_strb", 32'(strb), 32'(S_ILL));
`endif
      step();
      chk("ill_fetch", 32'(bus.state_o), 32'd1);
      chk("ill_no_illegal", 32'(bus.illegal), 32'd0);
      chk("ill_retired", bus.retired, 32'd4);

      // Reset asserted in the middle of a load's MEM stall
      bus.opcode = 7'b0000011;
      step();
      step();
      bus.mem_ready = 1'b0;
      step();
      chk("ab_mem", 32'(bus.state_o), 32'd4);
      #2;
      rst = 1'b1;
      #1;
      chk("ab_state", 32'(bus.state_o), 32'd0);
      chk("ab_strb", 32'(strb), 32'h0);
      chk("ab_retired", bus.retired, 32'd0);
      chk("ab_timeout", 32'(bus.mem_timeout), 32'd0);
      step();
      rst           = 1'b0;
      bus.mem_ready = 1'b1;
      chk("ab_idle", 32'(bus.state_o), 32'd0);
      step();
      chk("ab_restart", 32'(bus.state_o), 32'd1);
      chk("ab_restart_strb", 32'(strb), 32'(S_PCW | S_IRW | S_MRD));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle main control unit for the RV32 datapath: a state machine that sequences FETCH, DECODE, EXEC, MEM and WB over a shared instruction/data memory. For each opcode class it issues the datapath strobes (branch, mem_read, mem_to_reg, alu_op, mem_write, alu_src, reg_write) in the correct cycle. It also drives PC/IR write enables and waits on a memory ready handshake. It keeps a retired-instruction counter and a sticky memory-timeout flag.

## Interface
- ALUOP_W, 2: alu_op width; must be ≥2; bits above [1:0] are driven 0.
- CNT_W, 32: retired-instruction counter width.
- MAX_WAIT, 15: cycles a memory access may wait before mem_timeout is set; must be ≥1.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  instruction[6:0] from IR; valid from DECODE onward.
- mem_ready  in  1  memory completed the current access this cycle.
- pc_write, ir_write  out  1  PC and IR update enables.
- i_or_d  out  1  0 = address from PC, 1 = address from ALU result.
- branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write  out  1  datapath strobes.
- alu_op  out  ALUOP_W  00 = add, 01 = subtract/compare, 10 = funct decode.
- illegal  out  1  unknown-opcode indication.
- mem_timeout  out  1  sticky; set on wait overrun.
- retired  out  CNT_W  completed-instruction count.
- state_o  out  3  current state encoding.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Reset drives state IDLE, internal opcode register op_q=0, wait counter=0, retired=0 and mem_timeout=0.
- IDLE: all strobes 0; moves to FETCH on the next edge.
- FETCH: mem_read=1, i_or_d=0. pc_write and ir_write are driven equal to mem_ready (Mealy). On mem_ready go to DECODE; otherwise stay.
- DECODE: all strobes 0; op_q<=opcode. Next state:
  - 0110011 (R), 0000011 (load), 0100011 (store), 1100011 (branch) → EXEC.
  - any other opcode → see Configuration.
- EXEC: outputs by op_q class.
  - R: alu_op=10, alu_src=0.
  - load/store: alu_op=00, alu_src=1.
  - branch: alu_op=01, alu_src=0, branch=1.
  - Next state: branch → FETCH (retire); load/store → MEM; R → WB.
- MEM: i_or_d=1, alu_src=1, alu_op=00; mem_read=1 for load, mem_write=1 for store. Waits for mem_ready.
  - On mem_ready: load → WB; store → FETCH (retire).
- WB: reg_write=1; mem_to_reg=1 for load, 0 for R. Next state FETCH (retire).
- Any strobe not listed for a state is 0.
- Retire: retired increments by 1 on the edge leaving a terminal state and wraps modulo 2^CNT_W.
- Wait counter:
  - Counts cycles spent in FETCH or MEM with mem_ready=0.
  - Clears on mem_ready and on any state change.
  - When it reaches MAX_WAIT, mem_timeout is set. mem_timeout stays set until reset; the FSM keeps waiting.
  - The counter saturates at MAX_WAIT.
- Reset mid-operation aborts immediately: no retire, no strobes after rst rises.

## Timing
- Latency with zero-wait memory (mem_ready high on first cycle):
  - branch: 3 cycles (F, D, E).
  - store: 4 cycles (F, D, E, M).
  - R: 4 cycles (F, D, E, W).
  - load: 5 cycles (F, D, E, M, W).
- Each mem_ready-low cycle in FETCH or MEM adds one cycle.
- state_o, retired and mem_timeout are registered.
- The strobes are combinational from state and op_q; pc_write and ir_write additionally depend on mem_ready.
- mem_ready outside FETCH and MEM is ignored.
- opcode changing outside DECODE has no effect.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An unknown opcode in DECODE goes to TRAP.
  - TRAP drives illegal=1 with all other strobes 0, lasts 1 cycle, then returns to FETCH.
  - TRAP does not increment retired.
- ILLEGAL_TRAP_EN undefined:
  - An unknown opcode in DECODE goes directly to FETCH without retiring.
  - illegal is tied to 0; TRAP is unreachable.

## Test plan
- Reset then R-type (0110011), mem_ready held 1 → state_o 0,1,2,3,5,1; alu_op=10 in EXEC; reg_write=1 with mem_to_reg=0 in WB; retired=1.
- Load (0000011) with mem_ready low for 2 cycles in MEM → MEM lasts 3 cycles with mem_read=1 and i_or_d=1; WB shows mem_to_reg=1 and reg_write=1; retired increments once.
- Store followed by branch, zero-wait → mem_write=1 for 1 cycle; branch=1 with alu_op=01 in EXEC; the branch returns to FETCH after EXEC; retired +2 over 7 cycles.
- mem_ready held low in FETCH for MAX_WAIT+3 cycles → mem_timeout rises after exactly MAX_WAIT wait cycles and stays 1 after mem_ready returns.
- Opcode 1111111 → with ILLEGAL_TRAP_EN: state_o 2,6,1 and illegal=1 for one cycle, retired unchanged. Without it: state_o 2,1 and illegal=0.
- rst asserted during load MEM → state_o=0 and all strobes 0 asynchronously; retired=0; after release the sequence restarts at FETCH.
